gpr_file_sb: RTL and testbench
==============================

// Module: gpr_file_sb
// PURPOSE
// - Parametrised general-purpose register file with a write-pending scoreboard.
// - Successor to the fixed 8x16 GPR bank; sits between decode/issue and writeback.
// - Adds async reset to a programmable value, optional write-to-read bypass, and
//   per-register pending tracking so decode can stall on RAW hazards.
// PARAMETERS
// - NUM_REGS   8    number of registers, >=2, need not be a power of 2
// - DATA_W     16   register width in bits
// - ADDR_W     $clog2(NUM_REGS)  address width (derived, do not override)
// - RESET_VAL  1    value loaded into every register on reset
// - BYPASS     1    1: same-cycle write data forwarded to read ports; 0: none
// PORTS
// - clk          in   1         single clock, all state on posedge
// - rst_n        in   1         asynchronous, active-low reset
// - issue_en     in   1         mark issue_dest as pending (result in flight)
// - issue_dest   in   ADDR_W    register being issued
// - write_en     in   1         writeback strobe
// - write_dest   in   ADDR_W    writeback destination
// - write_data   in   DATA_W    writeback data
// - read_addr_1  in   ADDR_W    read port 1 address
// - read_addr_2  in   ADDR_W    read port 2 address
// - read_data_1  out  DATA_W    read port 1 data (combinational)
// - read_data_2  out  DATA_W    read port 2 data (combinational)
// - read_busy_1  out  1         port 1 register pending, data not yet valid
// - read_busy_2  out  1         port 2 register pending, data not yet valid
// - pending      out  NUM_REGS  scoreboard vector, bit i = register i pending
// - err_clr      in   1         clears wr_err (sync)
// - wr_err       out  1         sticky error flag
// BEHAVIOUR
// - Reset (rst_n=0, async): all regs=RESET_VAL, pending=0, wr_err=0.
//   Read outputs follow the reset contents immediately.
// - Write: on posedge with write_en and write_dest<NUM_REGS, reg<=write_data
//   and pending[write_dest]<=0. One cycle write latency.
// - Issue: on posedge with issue_en and issue_dest<NUM_REGS,
//   pending[issue_dest]<=1.
// - Issue and write to the same register in the same cycle: data is written
//   and pending ends at 1 (the new issue wins).
// - Issue and write to different registers in one cycle: both take effect.
// - Reads: combinational, zero latency. read_data_x=reg[read_addr_x] and
//   read_busy_x=pending[read_addr_x].
// - BYPASS=1: if write_en and write_dest==read_addr_x (in range), then
//   read_data_x=write_data and read_busy_x=0 in the same cycle.
//   With BYPASS=0, data and busy show the registered state only.
// - Out-of-range address (>=NUM_REGS):
//   - read: data=0, busy=0.
//   - write/issue: ignored, and wr_err<=1.
// - Write to a register whose pending bit is 0: the write is performed and
//   wr_err<=1 (unexpected writeback).
// - err_clr: wr_err<=0 unless a new error event occurs in the same cycle;
//   the error wins.
// - write_data must be known when write_en=1 (immediate assert, sim only).
// - No internal state machine besides the scoreboard. No throughput limit:
//   one issue and one write every cycle.
// TESTING
// - Reset release, NUM_REGS=8, DATA_W=16: all reads=16'h0001, pending=8'h00,
//   wr_err=0.
// - issue r3; next cycle read_addr_1=3 -> read_busy_1=1. Then write r3=16'hBEEF
//   with BYPASS=1 -> same cycle read_data_1=BEEF and busy_1=0. Next cycle
//   pending[3]=0.
// - Same-cycle issue r5 and write r5=16'h1234: next cycle reg5=1234 and
//   pending[5]=1. Repeat with BYPASS=0: write cycle read shows the old value.
// - Write r2 with pending[2]=0 -> reg2 updated and wr_err=1. Pulse err_clr ->
//   wr_err=0. err_clr together with a new bad write -> wr_err stays 1.
// - NUM_REGS=6: write to address 7 -> no reg changes and wr_err=1;
//   read address 6 -> data=0, busy=0.
// - Assert rst_n mid-traffic with pending=8'hFF -> registers and pending
//   restored asynchronously, before the next clk edge.

Source files
------------

// File: rtl/gpr_file_sb.sv
// gpr_file_sb
// Parametrised general-purpose register file with a write-pending scoreboard.
// It sits between decode/issue and writeback. Decode marks a destination as
// pending when it issues an instruction. Writeback stores the result and
// clears the pending bit. Readers see the pending bit as read_busy_x, so
// decode can stall on RAW hazards.
//
// Ports
//   clk                      single clock, all state updates on posedge
//   rst_n                    asynchronous active-low reset
//   issue_en / issue_dest    mark a register as pending (result in flight)
//   write_en / write_dest /  writeback strobe, destination and data
//   write_data
//   read_addr_1/2            combinational read port addresses
//   read_data_1/2            read data (zero for out-of-range addresses)
//   read_busy_1/2            pending bit of the addressed register
//   pending                  full scoreboard, bit i = register i pending
//   err_clr                  synchronous clear of wr_err
//   wr_err                   sticky flag: out-of-range write/issue, or a
//                            writeback to a register that was not pending
module gpr_file_sb #(
  parameter int                NUM_REGS  = 8,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(1),
  parameter bit                BYPASS    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   write_dest,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [ADDR_W-1:0]   read_addr_1,
  input  logic [ADDR_W-1:0]   read_addr_2,
  output logic [DATA_W-1:0]   read_data_1,
  output logic [DATA_W-1:0]   read_data_2,
  output logic                read_busy_1,
  output logic                read_busy_2,
  output logic [NUM_REGS-1:0] pending,
  input  logic                err_clr,
  output logic                wr_err
);

  // The address bus can encode more values than there are registers
  // when NUM_REGS is not a power of two. Range checks use one extra bit
  // so that the compare is width-clean.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending_reg;
  logic                wr_err_reg;
  logic                wr_err_next;

  logic wr_in_range;
  logic is_in_range;
  logic err_event;

  assign wr_in_range = ({1'b0, write_dest} < NUM_REGS_W);
  assign is_in_range = ({1'b0, issue_dest} < NUM_REGS_W);

  // ---------------------------------------------------------------------
  // Storage and scoreboard, one slice per register
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

      logic              wr_hit;
      logic              is_hit;
      logic [DATA_W-1:0] data_reg;
      logic              pend_reg;

      assign wr_hit = write_en && (write_dest == IDX);
      assign is_hit = issue_en && (issue_dest == IDX);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= RESET_VAL;
          pend_reg <= 1'b0;
        end else begin
          if (wr_hit) begin
            data_reg <= write_data;
          end
          // When an issue and a writeback hit the same register in one
          // cycle, the new issue owns the register, so the pending bit
          // stays set.
          if (is_hit) begin
            pend_reg <= 1'b1;
          end else if (wr_hit) begin
            pend_reg <= 1'b0;
          end
        end
      end

      assign regs[gi]        = data_reg;
      assign pending_reg[gi] = pend_reg;
    end
  endgenerate

  assign pending = pending_reg;

  // ---------------------------------------------------------------------
  // Sticky error flag. A new error event in the same cycle overrides
  // err_clr.
  // ---------------------------------------------------------------------
  always_comb begin
    err_event = 1'b0;
    if (write_en) begin
      if (!wr_in_range) begin
        err_event = 1'b1;
      end else if (!pending_reg[write_dest]) begin
        err_event = 1'b1;
      end
    end
    if (issue_en && !is_in_range) begin
      err_event = 1'b1;
    end
  end

  always_comb begin
    wr_err_next = wr_err_reg;
    if (err_event) begin
      wr_err_next = 1'b1;
    end else if (err_clr) begin
      wr_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= wr_err_next;
    end
  end

  assign wr_err = wr_err_reg;

  // ---------------------------------------------------------------------
  // Read ports (combinational). An address match with the current
  // writeback forwards the data and reports the register as not busy,
  // because the result is already on the bus.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = read_addr_1;
  assign rd_addr[1] = read_addr_2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = '0;
        rd_busy[gi] = 1'b0;
        if ({1'b0, rd_addr[gi]} < NUM_REGS_W) begin
          if (BYPASS && write_en && (write_dest == rd_addr[gi])) begin
            rd_data[gi] = write_data;
          end else begin
            rd_data[gi] = regs[rd_addr[gi]];
            rd_busy[gi] = pending_reg[rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign read_data_1 = rd_data[0];
  assign read_data_2 = rd_data[1];
  assign read_busy_1 = rd_busy[0];
  assign read_busy_2 = rd_busy[1];

`ifndef SYNTHESIS
  // Writeback data must be known whenever it is strobed.
  always @(posedge clk) begin
    if (rst_n && write_en) begin
      assert (!$isunknown(write_data))
        else $error("gpr_file_sb: write_data unknown while write_en=1");
    end
  end
`endif

endmodule

// File: tb/tb_gpr_file_sb.sv
// Testbench for gpr_file_sb. It drives three instances in parallel from one
// stimulus stream:
//   u_byp : 8 registers, bypass enabled
//   u_nob : 8 registers, bypass disabled
//   u_six : 6 registers, bypass enabled (covers the out-of-range addresses)
// A reference model holds the register contents and the pending set as
// plain arrays. The model is updated at each posedge from the spec rules.
// A compare process checks every output on every negedge. Directed
// literal checks fix the expected values of the model.
module tb_gpr_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_en = 1'b0;
  logic [2:0]  issue_dest = '0;
  logic        write_en = 1'b0;
  logic [2:0]  write_dest = '0;
  logic [15:0] write_data = '0;
  logic [2:0]  ra1 = '0;
  logic [2:0]  ra2 = '0;
  logic        err_clr = 1'b0;

  logic [15:0] rd1 [3];
  logic [15:0] rd2 [3];
  logic        bz1 [3];
  logic        bz2 [3];
  logic        err [3];
  logic [7:0]  pend [3];
  logic [7:0]  pend_byp, pend_nob;
  logic [5:0]  pend_six;

  always #5 clk = ~clk;

  gpr_file_sb #(.NUM_REGS(8), .DATA_W(16), .RESET_VAL(16'h0001), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_dest(issue_dest),
    .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
    .read_addr_1(ra1), .read_addr_2(ra2), .read_data_1(rd1[0]), .read_data_2(rd2[0]),
    .read_busy_1(bz1[0]), .read_busy_2(bz2[0]), .pending(pend_byp),
    .err_clr(err_clr), .wr_err(err[0]));

  gpr_file_sb #(.NUM_REGS(8), .DATA_W(16), .RESET_VAL(16'h0001), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_dest(issue_dest),
    .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
    .read_addr_1(ra1), .read_addr_2(ra2), .read_data_1(rd1[1]), .read_data_2(rd2[1]),
    .read_busy_1(bz1[1]), .read_busy_2(bz2[1]), .pending(pend_nob),
    .err_clr(err_clr), .wr_err(err[1]));

  gpr_file_sb #(.NUM_REGS(6), .DATA_W(16), .RESET_VAL(16'h0001), .BYPASS(1'b1)) u_six (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_dest(issue_dest),
    .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
    .read_addr_1(ra1), .read_addr_2(ra2), .read_data_1(rd1[2]), .read_data_2(rd2[2]),
    .read_busy_1(bz1[2]), .read_busy_2(bz2[2]), .pending(pend_six),
    .err_clr(err_clr), .wr_err(err[2]));

  assign pend[0] = pend_byp;
  assign pend[1] = pend_nob;
  assign pend[2] = {2'b00, pend_six};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_reg  [3][8];
  bit          m_pend [3][8];
  bit          m_err  [3];
  int          m_n    [3] = '{8, 8, 6};
  bit          m_byp  [3] = '{1'b1, 1'b0, 1'b1};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[k][i]  = 16'h0001;
        m_pend[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
    end
  endtask

  // One clock of register-file behaviour for instance k.
  task automatic model_step(input int k);
    bit bad;
    bad = 1'b0;
    if (write_en) begin
      if (int'(write_dest) >= m_n[k]) bad = 1'b1;
      else begin
        if (!m_pend[k][write_dest]) bad = 1'b1;   // unexpected writeback
        m_reg[k][write_dest]  = write_data;
        m_pend[k][write_dest] = 1'b0;
      end
    end
    if (issue_en) begin
      if (int'(issue_dest) >= m_n[k]) bad = 1'b1;
      else m_pend[k][issue_dest] = 1'b1;          // applied last: issue wins
    end
    if (bad) m_err[k] = 1'b1;
    else if (err_clr) m_err[k] = 1'b0;
  endtask

  task automatic model_read(input int k, input logic [2:0] a,
                            output logic [15:0] d, output logic b);
    d = 16'h0000;
    b = 1'b0;
    if (int'(a) < m_n[k]) begin
      if (m_byp[k] && write_en && write_dest == a) d = write_data;
      else begin
        d = m_reg[k][a];
        b = m_pend[k][a];
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        logic [15:0] d1, d2;
        logic        b1, b2;
        logic [7:0]  pv;
        model_read(k, ra1, d1, b1);
        model_read(k, ra2, d2, b2);
        pv = '0;
        for (int i = 0; i < m_n[k]; i++) pv[i] = m_pend[k][i];
        check($sformatf("u%0d read_data_1", k), {16'h0, rd1[k]}, {16'h0, d1});
        check($sformatf("u%0d read_data_2", k), {16'h0, rd2[k]}, {16'h0, d2});
        check($sformatf("u%0d read_busy_1", k), {31'h0, bz1[k]}, {31'h0, b1});
        check($sformatf("u%0d read_busy_2", k), {31'h0, bz2[k]}, {31'h0, b2});
        check($sformatf("u%0d pending", k), {24'h0, pend[k]}, {24'h0, pv});
        check($sformatf("u%0d wr_err", k), {31'h0, err[k]}, {31'h0, m_err[k]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit ie, input logic [2:0] id, input bit we, input logic [2:0] wd,
                       input logic [15:0] wdat, input logic [2:0] a1, input logic [2:0] a2,
                       input bit ec);
    issue_en = ie; issue_dest = id; write_en = we; write_dest = wd;
    write_data = wdat; ra1 = a1; ra2 = a2; err_clr = ec;
    $display("txn t=%0t issue=%0b/%0d write=%0b/%0d/%h rd=%0d,%0d err_clr=%0b",
             $time, ie, id, we, wd, wdat, a1, a2, ec);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Reset values
    drive(0, 0, 0, 0, 16'h0, 3'd0, 3'd7, 0); mid();
    check("reset rd1", {16'h0, rd1[0]}, 32'h0001);
    check("reset rd2", {16'h0, rd2[0]}, 32'h0001);
    check("reset pending", {24'h0, pend[0]}, 32'h00);
    check("reset wr_err", {31'h0, err[0]}, 32'h0);
    next_cycle();

    // Issue r3, then see it busy
    drive(1, 3, 0, 0, 16'h0, 3'd3, 3'd0, 0); next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd3, 3'd0, 0); mid();
    check("issue r3 busy_1", {31'h0, bz1[0]}, 32'h1);
    check("issue r3 pending", {24'h0, pend[0]}, 32'h08);
    next_cycle();

    // Writeback r3: bypass vs none
    drive(0, 0, 1, 3, 16'hBEEF, 3'd3, 3'd0, 0); mid();
    check("bypass r3 data", {16'h0, rd1[0]}, 32'hBEEF);
    check("bypass r3 busy", {31'h0, bz1[0]}, 32'h0);
    check("nobypass r3 data", {16'h0, rd1[1]}, 32'h0001);
    check("nobypass r3 busy", {31'h0, bz1[1]}, 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd3, 3'd0, 0); mid();
    check("r3 cleared pending", {24'h0, pend[0]}, 32'h00);
    check("nobypass r3 stored", {16'h0, rd1[1]}, 32'hBEEF);
    check("good write no err", {31'h0, err[0]}, 32'h0);
    next_cycle();

    // Same-cycle issue and write on r5
    drive(1, 5, 1, 5, 16'h1234, 3'd5, 3'd0, 0); mid();
    check("r5 bypass data", {16'h0, rd1[0]}, 32'h1234);
    check("r5 nobypass old", {16'h0, rd1[1]}, 32'h0001);
    next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd5, 3'd0, 0); mid();
    check("r5 stored", {16'h0, rd1[0]}, 32'h1234);
    check("r5 pending wins", {24'h0, pend[0]}, 32'h20);
    check("r5 unexpected err", {31'h0, err[0]}, 32'h1);
    next_cycle();

    // Clear the error, then an unexpected write to r2
    drive(0, 0, 0, 0, 16'h0, 3'd5, 3'd2, 1); next_cycle();
    drive(0, 0, 1, 2, 16'hAAAA, 3'd5, 3'd2, 0); mid();
    check("err_clr clears", {31'h0, err[0]}, 32'h0);
    next_cycle();
    drive(0, 0, 1, 2, 16'h5555, 3'd5, 3'd2, 1); mid();
    check("r2 written", {16'h0, rd2[1]}, 32'hAAAA);
    check("r2 write err", {31'h0, err[0]}, 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd5, 3'd2, 1); mid();
    check("error beats clr", {31'h0, err[0]}, 32'h1);
    check("r2 second write", {16'h0, rd2[1]}, 32'h5555);
    next_cycle();

    // Out-of-range accesses on the 6-register instance
    drive(0, 0, 1, 7, 16'h7777, 3'd6, 3'd7, 0); mid();
    check("six err cleared", {31'h0, err[2]}, 32'h0);
    check("six rd addr6 data", {16'h0, rd1[2]}, 32'h0);
    check("six rd addr6 busy", {31'h0, bz1[2]}, 32'h0);
    check("eight bypass r7", {16'h0, rd2[0]}, 32'h7777);
    next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd6, 3'd7, 0); mid();
    check("six oor write err", {31'h0, err[2]}, 32'h1);
    check("six rd addr7 data", {16'h0, rd2[2]}, 32'h0);
    check("eight r7 stored", {16'h0, rd2[1]}, 32'h7777);
    next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd0, 3'd1, 1); next_cycle();
    drive(1, 7, 0, 0, 16'h0, 3'd0, 3'd1, 0); next_cycle();
    drive(0, 0, 0, 0, 16'h0, 3'd0, 3'd1, 0); mid();
    check("six oor issue err", {31'h0, err[2]}, 32'h1);
    check("eight issue r7 ok", {31'h0, err[0]}, 32'h0);
    next_cycle();

    // Fill the scoreboard, then reset asynchronously mid-cycle
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 0, 0, 16'h0, 3'(i), 3'd5, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 16'h0, 3'd5, 3'd2, 0); mid();
    check("full pending", {24'h0, pend[0]}, 32'hFF);
    check("six full pending", {24'h0, pend[2]}, 32'h3F);
    next_cycle();
    drive(0, 0, 1, 4, 16'hCAFE, 3'd5, 3'd2, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst pending", {24'h0, pend[0]}, 32'h00);
    check("async rst rd1", {16'h0, rd1[1]}, 32'h0001);
    check("async rst rd2", {16'h0, rd2[1]}, 32'h0001);
    check("async rst wr_err", {31'h0, err[2]}, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Mixed back-to-back traffic, one issue and one write per cycle
    for (int i = 0; i < 24; i++) begin
      drive(1'(i % 2), 3'(i), 1'(i % 3 != 0), 3'(i + 5), 16'(i * 16'h1111 + 16'h0F0F),
            3'(i * 3), 3'(i + 5), 1'(i % 5 == 0));
      next_cycle();
    end

    drive(0, 0, 0, 0, 16'h0, 3'd0, 3'd0, 0); mid();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
